// File: rtl/inst_mem_ctrl_pkg.sv
// Shared types for the instruction memory loader/fetch controller.
// Loader FSM states and byte packing constants.
package inst_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    HDR,
    BODY,
    RUN
  } ld_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/inst_mem_ctrl_if.sv
// Bundle of loader, fetch and BRAM port signals.
// master = environment side, slave = controller side.
interface inst_mem_ctrl_if #(
  parameter int INST_MEM_WIDTH = 5
);

  logic [7:0]                byte_in;
  logic                      byte_valid;
  logic [INST_MEM_WIDTH-1:0] pc;
  logic                      fetch_req;
  logic [INST_MEM_WIDTH-1:0] mem_addr;
  logic [31:0]               mem_din;
  logic                      mem_we;
  logic                      mem_en;
  logic [31:0]               mem_dout;
  logic [31:0]               inst;
  logic                      inst_valid;
  logic                      loader_ready;
  logic                      ovf;

  modport master (
    output byte_in, byte_valid, pc, fetch_req,
    output mem_dout,
    input  mem_addr, mem_din, mem_we, mem_en,
    input  inst, inst_valid, loader_ready, ovf
  );

  modport slave (
    input  byte_in, byte_valid, pc, fetch_req,
    input  mem_dout,
    output mem_addr, mem_din, mem_we, mem_en,
    output inst, inst_valid, loader_ready, ovf
  );

endinterface

// File: rtl/inst_mem_ctrl_packer.sv
// Big-endian byte-to-word packer for the program loader.
// word/word_valid are combinational on the 4th byte.
module byte_packer
  import inst_mem_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (byte_valid) begin
      cnt_d   = cnt_q + CNT_W'(1);
      shift_d = {shift_q[15:0], byte_in};
    end
  end

  assign word = {shift_q, byte_in};
  assign word_valid = byte_valid &&
    (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge CLK) begin
    if (!reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/inst_mem_ctrl.sv
// Shares one BRAM port between the program loader and fetch.
// Loads N words after a length header, then serves fetches.
module inst_mem_ctrl
  import inst_mem_ctrl_pkg::*;
#(
  parameter int INST_MEM_WIDTH = 5
) (
  input logic           CLK,
  input logic           reset,
  inst_mem_ctrl_if.slave bus
);

  localparam int W = INST_MEM_WIDTH;
  localparam logic [32:0] DEPTH = 33'(1) << W;

  ld_state_t      state_q;
  logic [W-1:0]   wptr_q;
  logic [W-1:0]   waddr_q;
  logic [31:0]    wcnt_q;
  logic [31:0]    len_q;
  logic [31:0]    din_q;
  logic           we_q;
  logic           last_q;
  logic           ready_q;
  logic           ival_q;
  logic           ovf_q;

  logic           run;
  logic           byte_acc;
  logic [31:0]    word;
  logic           word_valid;

  assign run      = (state_q == RUN);
  assign byte_acc = bus.byte_valid && !run;

  byte_packer u_pack (
    .CLK        (CLK),
    .reset      (reset),
    .byte_in    (bus.byte_in),
    .byte_valid (byte_acc),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= HDR;
      wptr_q  <= '0;
      waddr_q <= '0;
      wcnt_q  <= '0;
      len_q   <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      ival_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      last_q <= 1'b0;
      ival_q <= run && bus.fetch_req;
      unique case (state_q)
        HDR: begin
          if (word_valid) begin
            len_q  <= word;
            wcnt_q <= '0;
            if (word == '0) begin
              state_q <= RUN;
              ready_q <= 1'b1;
            end else begin
              state_q <= BODY;
              ovf_q   <= {1'b0, word} > DEPTH;
            end
          end
        end
        BODY: begin
          if (word_valid) begin
            we_q    <= 1'b1;
            din_q   <= word;
            waddr_q <= wptr_q;
            wptr_q  <= wptr_q + W'(1);
            wcnt_q  <= wcnt_q + 32'd1;
            last_q  <= (wcnt_q + 32'd1 == len_q);
          end
          // Hand over only after the final write pulse
          if (last_q) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: ;
        default: state_q <= HDR;
      endcase
    end
  end

  assign bus.mem_addr     = run ? bus.pc : waddr_q;
  assign bus.mem_en       = run ? bus.fetch_req : we_q;
  assign bus.mem_we       = we_q && !run;
  assign bus.mem_din      = din_q;
  assign bus.inst         = bus.mem_dout;
  assign bus.inst_valid   = ival_q;
  assign bus.loader_ready = ready_q;
  assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Directed bench for inst_mem_ctrl: table of per-cycle vectors
// plus hand sequences for reset and depth overflow.
module tb_inst_mem_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rstA;
  logic rstB;

  inst_mem_ctrl_if #(.INST_MEM_WIDTH(5)) ifA ();
  inst_mem_ctrl_if #(.INST_MEM_WIDTH(2)) ifB ();

  inst_mem_ctrl #(.INST_MEM_WIDTH(5)) dutA (
    .CLK   (CLK),
    .reset (rstA),
    .bus   (ifA.slave)
  );

  inst_mem_ctrl #(.INST_MEM_WIDTH(2)) dutB (
    .CLK   (CLK),
    .reset (rstB),
    .bus   (ifB.slave)
  );

  logic [31:0] memA [32];
  logic [31:0] memB [4];

  always @(posedge CLK) begin
    if (ifA.mem_en) begin
      if (ifA.mem_we) memA[ifA.mem_addr] <= ifA.mem_din;
      ifA.mem_dout <= memA[ifA.mem_addr];
    end
    if (ifB.mem_en) begin
      if (ifB.mem_we) memB[ifB.mem_addr] <= ifB.mem_din;
      ifB.mem_dout <= memB[ifB.mem_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name,
                       input logic [79:0] got,
                       input logic [79:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        bv;
    logic [7:0]  b;
    logic        fr;
    logic [4:0]  pc;
    logic        chk;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic        rdy;
    logic        iv;
    logic [31:0] inst;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst_n, bv,
                     input logic [7:0] b,
                     input logic fr,
                     input logic [4:0] pc,
                     input logic chk, we,
                     input logic [4:0] addr,
                     input logic [31:0] din,
                     input logic rdy, iv,
                     input logic [31:0] inst);
    vec_t v;
    v.rst_n = rst_n; v.bv = bv; v.b = b;
    v.fr = fr; v.pc = pc; v.chk = chk;
    v.we = we; v.addr = addr; v.din = din;
    v.rdy = rdy; v.iv = iv; v.inst = inst;
    tbl.push_back(v);
  endtask

  task automatic byt(input logic [7:0] b, input logic rdy);
    add(1, 1, b, 0, 0, 1, 0, 0, 0, rdy, 0, 0);
  endtask

  task automatic wr(input logic [7:0] b,
                    input logic [4:0] a,
                    input logic [31:0] d);
    add(1, 1, b, 0, 0, 1, 1, a, d, 0, 0, 0);
  endtask

  task automatic rst_row();
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic stepB(input logic bv,
                       input logic [7:0] b,
                       input logic fr,
                       input logic [1:0] pc);
    @(negedge CLK);
    rstB = 1'b1;
    ifB.byte_valid = bv;
    ifB.byte_in = b;
    ifB.fetch_req = fr;
    ifB.pc = pc;
    #1;
  endtask

  logic [79:0] got, exp;
  logic        exp_en;
  logic [31:0] hdr;
  logic [31:0] wb [5];

  initial begin
    rstA = 1'b0; rstB = 1'b0;
    ifA.byte_valid = 0; ifA.byte_in = 0;
    ifA.fetch_req = 0; ifA.pc = 0;
    ifB.byte_valid = 0; ifB.byte_in = 0;
    ifB.fetch_req = 0; ifB.pc = 0;

    // load 2 words, then fetch both
    byt(8'h00, 0); byt(8'h00, 0);
    byt(8'h00, 0); byt(8'h02, 0);
    byt(8'hDE, 0); byt(8'hAD, 0);
    byt(8'hBE, 0); byt(8'hEF, 0);
    wr(8'h12, 5'd0, 32'hDEADBEEF);
    byt(8'h34, 0); byt(8'h56, 0); byt(8'h78, 0);
    add(1, 0, 0, 0, 0, 1, 1, 1, 32'h12345678, 0, 0, 0);
    add(1, 1, 8'hAB, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 32'hDEADBEEF);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h12345678);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    // zero-length header, BRAM kept across reset
    rst_row();
    byt(8'h00, 0); byt(8'h00, 0);
    byt(8'h00, 0); byt(8'h00, 0);
    byt(8'h11, 1); byt(8'h22, 1);
    byt(8'h33, 1); byt(8'h44, 1); byt(8'h55, 1);
    add(1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h12345678);
    // reset on the 4th byte suppresses the pulse
    rst_row();
    byt(8'h00, 0); byt(8'h00, 0);
    byt(8'h00, 0); byt(8'h01, 0);
    byt(8'h01, 0); byt(8'h02, 0); byt(8'h03, 0);
    add(0, 1, 8'h04, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset after 6 of 8 body bytes
    byt(8'h00, 0); byt(8'h00, 0);
    byt(8'h00, 0); byt(8'h02, 0);
    byt(8'hAA, 0); byt(8'hBB, 0);
    byt(8'hCC, 0); byt(8'hDD, 0);
    wr(8'h11, 5'd0, 32'hAABBCCDD);
    byt(8'h22, 0);
    rst_row();
    byt(8'h00, 0); byt(8'h00, 0);
    byt(8'h00, 0); byt(8'h01, 0);
    byt(8'h55, 0); byt(8'h66, 0);
    byt(8'h77, 0); byt(8'h88, 0);
    add(1, 0, 0, 0, 0, 1, 1, 0, 32'h55667788, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    // reset in RUN drops the pending fetch result
    add(0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 32'h55667788);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // reset for two edges, then fetch attempts in HDR
    repeat (2) @(negedge CLK);
    rstA = 1'b1;
    ifA.fetch_req = 1'b1;
    ifA.pc = 5'd3;
    #1;
    check("rst_we",  80'(ifA.mem_we), 80'd0);
    check("rst_din", 80'(ifA.mem_din), 80'd0);
    check("rst_rdy", 80'(ifA.loader_ready), 80'd0);
    check("rst_iv",  80'(ifA.inst_valid), 80'd0);
    check("rst_ovf", 80'(ifA.ovf), 80'd0);
    check("rst_en",  80'(ifA.mem_en), 80'd0);
    @(negedge CLK);
    #1;
    check("hdr_fetch_iv", 80'(ifA.inst_valid), 80'd0);
    check("hdr_fetch_en", 80'(ifA.mem_en), 80'd0);

    foreach (tbl[i]) begin
      @(negedge CLK);
      rstA = tbl[i].rst_n;
      ifA.byte_valid = tbl[i].bv;
      ifA.byte_in = tbl[i].b;
      ifA.fetch_req = tbl[i].fr;
      ifA.pc = tbl[i].pc;
      #1;
      if (tbl[i].chk) begin
        exp_en = tbl[i].rdy ? tbl[i].fr : tbl[i].we;
        got = {ifA.mem_we, ifA.mem_en,
               ifA.loader_ready, ifA.inst_valid, ifA.ovf,
               tbl[i].we ? ifA.mem_addr : 5'd0,
               tbl[i].we ? ifA.mem_din : 32'd0,
               tbl[i].iv ? ifA.inst : 32'd0};
        exp = {tbl[i].we, exp_en,
               tbl[i].rdy, tbl[i].iv, 1'b0,
               tbl[i].we ? tbl[i].addr : 5'd0,
               tbl[i].we ? tbl[i].din : 32'd0,
               tbl[i].iv ? tbl[i].inst : 32'd0};
        check($sformatf("rowA%0d", i), got, exp);
      end
    end

    // depth-4 BRAM, header N=5: overflow and wrap
    wb[0] = 32'hA0B0C0D0; wb[1] = 32'hA1B1C1D1;
    wb[2] = 32'hA2B2C2D2; wb[3] = 32'hA3B3C3D3;
    wb[4] = 32'hA4B4C4D4;
    hdr = 32'd5;
    for (int k = 0; k < 4; k++)
      stepB(1, hdr[31-8*k -: 8], 0, 0);
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 4; k++) begin
        stepB(1, wb[w][31-8*k -: 8], 0, 0);
        if (k == 0) begin
          if (w == 0)
            check("B_ovf",
              80'({ifB.ovf, ifB.mem_we, ifB.loader_ready}),
              80'({1'b1, 1'b0, 1'b0}));
          else
            check($sformatf("B_wr%0d", w - 1),
              80'({ifB.mem_we, ifB.mem_addr, ifB.mem_din,
                   ifB.loader_ready}),
              80'({1'b1, 2'(w - 1), wb[w-1], 1'b0}));
        end
      end
    end
    stepB(0, 0, 0, 0);
    check("B_wr4",
      80'({ifB.mem_we, ifB.mem_addr, ifB.mem_din,
           ifB.loader_ready}),
      80'({1'b1, 2'd0, wb[4], 1'b0}));
    stepB(0, 0, 1, 0);
    check("B_run",
      80'({ifB.loader_ready, ifB.mem_we, ifB.ovf}),
      80'({1'b1, 1'b0, 1'b1}));
    stepB(0, 0, 1, 1);
    check("B_fetch0",
      80'({ifB.inst_valid, ifB.inst}),
      80'({1'b1, wb[4]}));
    stepB(0, 0, 0, 0);
    check("B_fetch1",
      80'({ifB.inst_valid, ifB.inst}),
      80'({1'b1, wb[1]}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_mem_ctrl.md
# inst_mem_ctrl

Controller for the single-port instruction BRAM: a byte-stream program loader and the core's fetch port share one BRAM port. After reset it assembles incoming bytes into 32-bit words and writes them to consecutive addresses. It then hands the port to the fetch stage and signals `loader_ready` as a level. It sits between the serial receiver, the instruction BRAM and the fetch stage.

## Interface
- `INST_MEM_WIDTH`, default 5: BRAM address width; depth = 2**INST_MEM_WIDTH words.
- `CLK` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `byte_in` in 8: loader data byte.
- `byte_valid` in 1: `byte_in` accepted this cycle. There is no backpressure.
- `pc` in INST_MEM_WIDTH: fetch address.
- `fetch_req` in 1: fetch request, honoured only in RUN.
- `mem_addr` out INST_MEM_WIDTH: BRAM address.
- `mem_din` out 32: BRAM write data.
- `mem_we` out 1: BRAM write enable.
- `mem_en` out 1: BRAM enable.
- `mem_dout` in 32: BRAM read data, 1-cycle latency.
- `inst` out 32: fetched instruction.
- `inst_valid` out 1: `inst` valid this cycle.
- `loader_ready` out 1: level; high while in RUN.
- `ovf` out 1: sticky; the program header exceeded BRAM depth.

## Operation
- Reset values (reset low at an edge):
  - state = HDR; byte count = 0; write pointer = 0; word count = 0.
  - `mem_we` = 0, `mem_din` = 0, `inst_valid` = 0, `loader_ready` = 0, `ovf` = 0.
  - BRAM contents are not cleared.
- Byte packing:
  - The first accepted byte of each group is bits 31:24 (big-endian).
  - The 4th byte completes the word.
  - The packing counter wraps 3→0.
- HDR state:
  - The first completed word is the program length N (unsigned 32-bit). It is not written to BRAM.
  - N = 0 → RUN.
  - N ≠ 0 → BODY; `ovf` is set if N > 2**INST_MEM_WIDTH.
- BODY state:
  - Each completed word is written at the write pointer, which then increments modulo depth.
  - When the Nth word is written → RUN.
  - With `ovf`, excess words overwrite from address 0 (wrap).
- RUN state:
  - `mem_addr` = `pc`, `mem_en` = `fetch_req`, `mem_we` = 0.
  - `byte_valid` is ignored.
  - The state is terminal until reset.
- `inst` is a combinational pass-through of `mem_dout`.
- `fetch_req` in HDR or BODY is ignored: no BRAM access and no `inst_valid`.

## Timing
- Load write:
  - The 4th byte of a word is accepted at edge t.
  - At t+1: `mem_we` = 1, `mem_addr` = write pointer, `mem_din` = word. This is a single-cycle pulse.
  - In HDR/BODY, `mem_en` = `mem_we`.
- Handover:
  - The last body write pulse is the cycle after edge t.
  - The state is RUN and `loader_ready` = 1 from the cycle after that write pulse.
  - For N = 0, `loader_ready` = 1 the cycle after the 4th header byte is accepted.
- Fetch:
  - `fetch_req` = 1 with `pc` = A in cycle c (RUN) → `inst_valid` = 1 and `inst` = mem[A] in cycle c+1.
  - Back-to-back requests give one result per cycle.
- Simultaneous events:
  - A `byte_valid` that arrives in the write-pulse cycle is accepted normally.
  - The writes never collide, since at most one word completes per 4 bytes.
- `byte_valid` arriving in the cycle `loader_ready` rises is dropped.
- Reset mid-load:
  - The partial word is discarded; the machine returns to HDR.
  - Any `mem_we` pulse pending for the next cycle is suppressed.
- Reset in RUN: `inst_valid` is 0 in the next cycle.

## Structure
- Package `inst_mem_ctrl_pkg`:
  - State enum `ld_state_t` {HDR, BODY, RUN}.
  - `BYTES_PER_WORD` = 4.
- Sub-module `byte_packer` (CLK, reset, `byte_in`, `byte_valid` → `word`, `word_valid` pulse).
  - Shifts the bytes in and pulses on the 4th.
  - The controller owns the FSM, write pointer, word counter and port muxing.

## Test plan
1. Reset low for 2 cycles, then release → all outputs 0, `loader_ready` = 0; `fetch_req` = 1 with `pc` = 3 → `inst_valid` stays 0.
2. Stream 00 00 00 02, then DE AD BE EF, then 12 34 56 78 → writes DEADBEEF@0 and 12345678@1, each a single `mem_we` pulse one cycle after its 4th byte; `loader_ready` rises the cycle after the second write.
3. After test 2, `fetch_req` with `pc` = 0, then 1, on consecutive cycles → `inst` = DEADBEEF then 12345678 on the following cycles, with `inst_valid` high for 2 cycles.
4. Header 00 00 00 00 → no writes; `loader_ready` = 1 one cycle after the 4th header byte; later bytes produce no `mem_we`.
5. `INST_MEM_WIDTH` = 2, header N = 5 → `ovf` = 1 after the header; the 5th word is written at address 0; RUN is entered after the 5th write.
6. Reset asserted after 6 of 8 body bytes (N = 2) → no write for the partial word; a new header 00 00 00 01 plus 1 word then writes at address 0 and enters RUN.
